// File: rtl/cmp_result_stats.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_result_stats
//  Purpose  : Statistics collector for the 2-bit comparator flags f1/f2/f3.
//             Keeps saturating per-outcome counters and a run length.
//             Flags non-one-hot samples with a sticky err bit.
//             Streams a snapshot of the counters as tagged words over
//             out_valid/out_ready.
//  Options  : CMP_TOTAL_WORD_EN adds a total-of-legal-samples counter.
//             It is sent as a fourth report word with tag 3.
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_result_stats #(
   parameter int CNT_W = 8,
   parameter int RUN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             f1,
   input  logic             f2,
   input  logic             f3,
   input  logic             clear,
   input  logic             report_req,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_tag,
   output logic [CNT_W-1:0] out_data,
   output logic [RUN_W-1:0] run_len,
   output logic             err,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [RUN_W-1:0] RUN_MAX = '1;
   localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

   // Outcome codes; NONE marks "no previous legal outcome"
   localparam logic [1:0] OUT_NONE = 2'd0;
   localparam logic [1:0] OUT_GT   = 2'd1;
   localparam logic [1:0] OUT_EQ   = 2'd2;
   localparam logic [1:0] OUT_LT   = 2'd3;

   typedef enum logic [2:0] {
      ACCUM   = 3'd0,
      SEND_GT = 3'd1,
      SEND_EQ = 3'd2,
`ifdef CMP_TOTAL_WORD_EN
      SEND_LT = 3'd3,
      SEND_TOT = 3'd4
`else
      SEND_LT = 3'd3
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt_gt, cnt_eq, cnt_lt;
   logic [CNT_W-1:0] snap_eq, snap_lt;
   logic [1:0]       last;
   logic [1:0]       flag_sum;
   logic [1:0]       code;
   logic             legal;
`ifdef CMP_TOTAL_WORD_EN
   logic [CNT_W-1:0] cnt_tot, snap_tot;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // Decode the flag triple into a legality bit and an outcome code
   always_comb begin
      flag_sum = {1'b0, f1} + {1'b0, f2} + {1'b0, f3};
      legal    = in_valid && (flag_sum == 2'd1);
      code     = OUT_NONE;
      if (f1)      code = OUT_GT;
      else if (f2) code = OUT_EQ;
      else if (f3) code = OUT_LT;
   end

   // Live counters, run length and sticky error; clear beats any sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_gt  <= '0;
         cnt_eq  <= '0;
         cnt_lt  <= '0;
         run_len <= '0;
         last    <= OUT_NONE;
         err     <= 1'b0;
`ifdef CMP_TOTAL_WORD_EN
         cnt_tot <= '0;
`endif
      end else if (clear) begin
         cnt_gt  <= '0;
         cnt_eq  <= '0;
         cnt_lt  <= '0;
         run_len <= '0;
         last    <= OUT_NONE;
         err     <= 1'b0;
`ifdef CMP_TOTAL_WORD_EN
         cnt_tot <= '0;
`endif
      end else if (legal) begin
         case (code)
            OUT_GT:  cnt_gt <= sat_inc(cnt_gt);
            OUT_EQ:  cnt_eq <= sat_inc(cnt_eq);
            default: cnt_lt <= sat_inc(cnt_lt);
         endcase
`ifdef CMP_TOTAL_WORD_EN
         cnt_tot <= sat_inc(cnt_tot);
`endif
         if (code == last)
            run_len <= (run_len == RUN_MAX) ? run_len : run_len + RUN_ONE;
         else
            run_len <= RUN_ONE;
         last <= code;
      end else if (in_valid) begin
         run_len <= '0;
         last    <= OUT_NONE;
         err     <= 1'b1;
      end
   end

   // Report FSM; the GT snapshot lives directly in out_data, others in snap_*
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         out_valid <= 1'b0;
         out_tag   <= 2'd0;
         out_data  <= '0;
         snap_eq   <= '0;
         snap_lt   <= '0;
`ifdef CMP_TOTAL_WORD_EN
         snap_tot  <= '0;
`endif
      end else begin
         case (state)
            ACCUM: begin
               if (report_req) begin
                  snap_eq   <= cnt_eq;
                  snap_lt   <= cnt_lt;
`ifdef CMP_TOTAL_WORD_EN
                  snap_tot  <= cnt_tot;
`endif
                  state     <= SEND_GT;
                  out_valid <= 1'b1;
                  out_tag   <= 2'd0;
                  out_data  <= cnt_gt;
               end
            end
            SEND_GT: begin
               if (out_ready) begin
                  state    <= SEND_EQ;
                  out_tag  <= 2'd1;
                  out_data <= snap_eq;
               end
            end
            SEND_EQ: begin
               if (out_ready) begin
                  state    <= SEND_LT;
                  out_tag  <= 2'd2;
                  out_data <= snap_lt;
               end
            end
            SEND_LT: begin
               if (out_ready) begin
`ifdef CMP_TOTAL_WORD_EN
                  state     <= SEND_TOT;
                  out_tag   <= 2'd3;
                  out_data  <= snap_tot;
`else
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  out_tag   <= 2'd0;
                  out_data  <= '0;
`endif
               end
            end
`ifdef CMP_TOTAL_WORD_EN
            SEND_TOT: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  out_tag   <= 2'd0;
                  out_data  <= '0;
               end
            end
`endif
            default: begin
               state     <= ACCUM;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_cmp_result_stats.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_result_stats
//  Purpose  : Directed self-checking bench for cmp_result_stats.
//             A queue-based model predicts counters and report words.
//             It honours CMP_TOTAL_WORD_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_result_stats;

   localparam int CNT_W = 8;
   localparam int RUN_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int RMAX  = (1 << RUN_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
   logic             clear = 1'b0;
   logic             report_req = 1'b0;
   logic             out_ready = 1'b1;
   logic             out_valid;
   logic [1:0]       out_tag;
   logic [CNT_W-1:0] out_data;
   logic [RUN_W-1:0] run_len;
   logic             err;
   logic             busy;

   cmp_result_stats #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .f1(f1), .f2(f2), .f3(f3), .clear(clear), .report_req(report_req),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_data(out_data), .run_len(run_len), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Model state
   typedef struct { int tag; int data; } word_t;
   int    m_cnt [3];
   int    m_tot;
   int    m_run;
   int    m_last = -1;
   bit    m_err;
   word_t m_q[$];

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_tot  = 0;
      m_run  = 0;
      m_last = -1;
      m_err  = 0;
      m_q.delete();
   endtask

   // Apply one clock edge to the model, using the inputs present at that edge
   task automatic model_edge();
      bit    was_busy;
      int    nf;
      int    k;
      word_t w;
      if (!rst_n) begin
         model_reset();
         return;
      end
      was_busy = (m_q.size() != 0);
      if (was_busy && out_ready) void'(m_q.pop_front());
      if (!was_busy && report_req) begin
         for (int i = 0; i < 3; i++) begin
            w.tag = i; w.data = m_cnt[i];
            m_q.push_back(w);
         end
`ifdef CMP_TOTAL_WORD_EN
         w.tag = 3; w.data = m_tot;
         m_q.push_back(w);
`endif
      end
      if (clear) begin
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
         m_tot = 0; m_run = 0; m_last = -1; m_err = 0;
      end else if (in_valid) begin
         nf = int'(f1) + int'(f2) + int'(f3);
         if (nf == 1) begin
            k = f1 ? 0 : (f2 ? 1 : 2);
            if (m_cnt[k] < CMAX) m_cnt[k]++;
            if (m_tot < CMAX) m_tot++;
            if (k == m_last) m_run = (m_run < RMAX) ? m_run + 1 : RMAX;
            else             m_run = 1;
            m_last = k;
         end else begin
            m_run = 0; m_last = -1; m_err = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic drive(input bit iv, input bit a, input bit b, input bit c);
      in_valid = iv; f1 = a; f2 = b; f3 = c;
      step();
      in_valid = 0; f1 = 0; f2 = 0; f3 = 0;
   endtask

   task automatic do_clear();
      clear = 1;
      step();
      clear = 0;
   endtask

   // Full report with out_ready high; words checked against literal values
   task automatic do_report(input int gt, input int eq, input int lt, input int tot);
      out_ready  = 1;
      report_req = 1;
      step();
      report_req = 0;
      check("rep_gt_valid", int'(out_valid), 1);
      check("rep_gt_busy", int'(busy), 1);
      check("rep_gt_tag", int'(out_tag), 0);
      check("rep_gt_data", int'(out_data), gt);
      step();
      check("rep_eq_tag", int'(out_tag), 1);
      check("rep_eq_data", int'(out_data), eq);
      step();
      check("rep_lt_tag", int'(out_tag), 2);
      check("rep_lt_data", int'(out_data), lt);
      step();
`ifdef CMP_TOTAL_WORD_EN
      check("rep_tot_tag", int'(out_tag), 3);
      check("rep_tot_data", int'(out_data), tot);
      step();
`else
      if (tot < 0) $display("note: negative total ignored");
`endif
      check("rep_end_valid", int'(out_valid), 0);
      check("rep_end_busy", int'(busy), 0);
   endtask

   // Every-cycle comparison of all DUT outputs against the model
   always @(negedge clk) begin
      check("cyc_run_len", int'(run_len), m_run);
      check("cyc_err", int'(err), int'(m_err));
      check("cyc_busy", int'(busy), int'(m_q.size() != 0));
      check("cyc_out_valid", int'(out_valid), int'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("cyc_out_tag", int'(out_tag), m_q[0].tag);
         check("cyc_out_data", int'(out_data), m_q[0].data);
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_out_tag", int'(out_tag), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_run_len", int'(run_len), 0);
      check("rst_err", int'(err), 0);
      @(posedge clk);
      #1;
      rst_n = 1;

      // Run length across f1,f1,f2 then f3,f3
      drive(1, 1, 0, 0); check("run_a", int'(run_len), 1);
      drive(1, 1, 0, 0); check("run_b", int'(run_len), 2);
      drive(1, 0, 1, 0); check("run_c", int'(run_len), 1);
      check("err_legal", int'(err), 0);
      drive(0, 1, 0, 0); check("run_idle", int'(run_len), 1);
      drive(1, 0, 0, 1); check("run_d", int'(run_len), 1);
      drive(1, 0, 0, 1); check("run_e", int'(run_len), 2);
      do_report(2, 1, 2, 5);

      // Stall on the EQ word while sampling; a report_req while busy is dropped
      report_req = 1;
      step();
      report_req = 0;
      step();
      check("stall_tag0", int'(out_tag), 1);
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         report_req = 1;
         drive(1, 0, (i < 2), 0);
         check("stall_tag", int'(out_tag), 1);
         check("stall_data", int'(out_data), 1);
         check("stall_valid", int'(out_valid), 1);
      end
      report_req = 0;
      out_ready = 1;
      step();
      check("drain_lt", int'(out_data), 2);
      step();
`ifdef CMP_TOTAL_WORD_EN
      step();
`endif
      do_report(2, 3, 2, 7);

      // Saturation of counters and run length
      do_clear();
      for (int i = 0; i < 260; i++) drive(1, 0, 0, 1);
      check("sat_run", int'(run_len), RMAX);
      do_report(0, 0, 255, 255);

      // Illegal samples and sticky err
      do_clear();
      drive(1, 1, 1, 0);
      check("ill_run", int'(run_len), 0);
      check("ill_err", int'(err), 1);
      drive(1, 0, 0, 0);
      check("ill0_err", int'(err), 1);
      drive(1, 1, 1, 1);
      drive(1, 1, 0, 0);
      check("post_ill_run", int'(run_len), 1);
      check("post_ill_err", int'(err), 1);
      // clear wins over a coincident sample
      in_valid = 1; f2 = 1;
      do_clear();
      in_valid = 0; f2 = 0;
      check("clr_err", int'(err), 0);
      check("clr_run", int'(run_len), 0);
      do_report(0, 0, 0, 0);

      // Asynchronous reset in the middle of a report
      drive(1, 1, 0, 0);
      drive(1, 0, 1, 0);
      report_req = 1;
      step();
      report_req = 0;
      step();
      check("mid_tag", int'(out_tag), 1);
      #2;
      rst_n = 0;
      model_reset();
      #1;
      check("arst_valid", int'(out_valid), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_data", int'(out_data), 0);
      check("arst_run", int'(run_len), 0);
      step();
      step();
      rst_n = 1;
      do_report(0, 0, 0, 0);

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
